// File: rtl/lsu_unit.sv
// Sequential load/store unit: one request at a time, aligned bus beats with byte strobes,
// lane-shifted store data and extended load data. Build option: MISALIGNED_EN (split crossing beats).
module lsu_unit #(
  parameter int XLEN = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_store,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [XLEN-1:0]   i_req_addr,
  input  logic [XLEN-1:0]   i_req_wdata,
  output logic              o_rsp_valid,
  output logic              o_rsp_error,
  output logic [XLEN-1:0]   o_rsp_rdata,
  output logic              o_mem_valid,
  input  logic              i_mem_ready,
  output logic              o_mem_write,
  output logic [XLEN-1:0]   o_mem_addr,
  output logic [XLEN/8-1:0] o_mem_strb,
  output logic [XLEN-1:0]   o_mem_wdata,
  input  logic [XLEN-1:0]   i_mem_rdata,
  input  logic              i_mem_error
);

  localparam int NB  = XLEN / 8;
  localparam int OFS = $clog2(NB);
  localparam int SHW = OFS + 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
`ifdef MISALIGNED_EN
    S_BEAT1 = 2'd2,
`endif
    S_RESP  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_store;
  logic            r_unsigned;
  logic [1:0]      r_size;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic            r_rsp_error;
  logic [XLEN-1:0] r_rsp_rdata;

  logic            w_req_illegal;
  logic            w_req_misal;
  logic            w_req_err;

  assign w_req_illegal = (XLEN == 32) && (i_req_size == 2'd3);

`ifdef MISALIGNED_EN
  assign w_req_misal = 1'b0;
`else
  logic [3:0] w_req_bytes;
  assign w_req_bytes = 4'd1 << i_req_size;
  assign w_req_misal = (i_req_addr[OFS-1:0] & OFS'(w_req_bytes - 4'd1)) != '0;
`endif

  assign w_req_err = w_req_illegal || w_req_misal;

  // Per-beat views of the latched request
  logic [OFS-1:0]  w_ofs;
  logic [3:0]      w_bytes;
  logic [7:0]      w_strb_base;
  logic [XLEN-1:0] w_base_addr;
  logic [XLEN-1:0] w_wdata0;
  logic [NB-1:0]   w_strb0;
  logic [XLEN-1:0] w_load0;

  assign w_ofs       = r_addr[OFS-1:0];
  assign w_bytes     = 4'd1 << r_size;
  assign w_strb_base = 8'((9'h1 << w_bytes) - 9'h1);
  assign w_base_addr = {r_addr[XLEN-1:OFS], {OFS{1'b0}}};
  assign w_wdata0    = r_wdata << {w_ofs, 3'b000};
  assign w_strb0     = NB'((2*NB)'(w_strb_base) << w_ofs);
  assign w_load0     = i_mem_rdata >> {w_ofs, 3'b000};

`ifdef MISALIGNED_EN
  logic [XLEN-1:0] r_lo;
  logic            w_cross;
  logic [SHW-1:0]  w_hi_sh;
  logic [NB-1:0]   w_strb1;
  logic [XLEN-1:0] w_wdata1;
  logic [XLEN-1:0] w_addr1;
  logic [XLEN-1:0] w_load1;

  assign w_cross  = (5'(w_ofs) + 5'(w_bytes)) > 5'(NB);
  // Bit distance from the top of beat0's data to the first byte carried by beat1
  assign w_hi_sh  = SHW'(XLEN) - SHW'({w_ofs, 3'b000});
  assign w_strb1  = NB'(w_strb_base >> (NB - int'(w_ofs)));
  assign w_wdata1 = r_wdata >> w_hi_sh;
  assign w_addr1  = w_base_addr + XLEN'(NB);
  assign w_load1  = r_lo | (i_mem_rdata << w_hi_sh);
`endif

  function automatic logic [XLEN-1:0] f_extend(input logic [XLEN-1:0] raw,
                                               input logic [1:0] size,
                                               input logic uns);
    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] res;
    int              nbits;
    nbits = 8 << size;
    res   = raw;
    if (nbits < XLEN) begin
      mask = (XLEN'(1) << nbits) - XLEN'(1);
      res  = raw & mask;
      if (!uns && raw[nbits-1]) res = res | ~mask;
    end
    return res;
  endfunction

  always_comb begin
    w_state_next = r_state;
    o_req_ready  = 1'b0;
    o_mem_valid  = 1'b0;
    o_mem_write  = 1'b0;
    o_mem_addr   = '0;
    o_mem_strb   = '0;
    o_mem_wdata  = '0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) w_state_next = w_req_err ? S_RESP : S_BEAT0;
      end
      S_BEAT0: begin
        o_mem_valid = 1'b1;
        o_mem_write = r_store;
        o_mem_addr  = w_base_addr;
        o_mem_strb  = w_strb0;
        o_mem_wdata = w_wdata0;
        if (i_mem_ready) begin
`ifdef MISALIGNED_EN
          w_state_next = (w_cross && !i_mem_error) ? S_BEAT1 : S_RESP;
`else
          w_state_next = S_RESP;
`endif
        end
      end
`ifdef MISALIGNED_EN
      S_BEAT1: begin
        o_mem_valid = 1'b1;
        o_mem_write = r_store;
        o_mem_addr  = w_addr1;
        o_mem_strb  = w_strb1;
        o_mem_wdata = w_wdata1;
        if (i_mem_ready) w_state_next = S_RESP;
      end
`endif
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_store     <= 1'b0;
      r_unsigned  <= 1'b0;
      r_size      <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_error <= 1'b0;
      r_rsp_rdata <= '0;
`ifdef MISALIGNED_EN
      r_lo        <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_store     <= i_req_store;
            r_unsigned  <= i_req_unsigned;
            r_size      <= i_req_size;
            r_addr      <= i_req_addr;
            r_wdata     <= i_req_wdata;
            r_rsp_error <= w_req_err;
            r_rsp_rdata <= '0;
          end
        end
        S_BEAT0: begin
          if (i_mem_ready) begin
`ifdef MISALIGNED_EN
            r_lo <= w_load0;
`endif
            // A crossing load overwrites this result when beat1 completes
            r_rsp_error <= i_mem_error;
            r_rsp_rdata <= (r_store || i_mem_error) ? '0
                           : f_extend(w_load0, r_size, r_unsigned);
          end
        end
`ifdef MISALIGNED_EN
        S_BEAT1: begin
          if (i_mem_ready) begin
            r_rsp_error <= i_mem_error;
            r_rsp_rdata <= (r_store || i_mem_error) ? '0
                           : f_extend(w_load1, r_size, r_unsigned);
          end
        end
`endif
        S_RESP: begin
          r_rsp_error <= 1'b0;
          r_rsp_rdata <= '0;
        end
        default: ;
      endcase
    end
  end

  assign o_rsp_valid = (r_state == S_RESP);
  assign o_rsp_error = o_rsp_valid & r_rsp_error;
  assign o_rsp_rdata = o_rsp_valid ? r_rsp_rdata : '0;

endmodule

// File: tb/tb_lsu_unit.sv
// Directed bench for lsu_unit (XLEN=32): latency, strobes, lane shifting, extension, errors, reset.
module tb_lsu_unit;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid, req_ready, req_store, req_unsigned;
  logic [1:0]      req_size;
  logic [XLEN-1:0] req_addr, req_wdata;
  logic            rsp_valid, rsp_error;
  logic [XLEN-1:0] rsp_rdata;
  logic            mem_valid, mem_ready, mem_write, mem_error;
  logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]      mem_strb;

  int n_total = 0;
  int n_fail  = 0;

  lsu_unit #(.XLEN(XLEN)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_store(req_store),
    .i_req_size(req_size), .i_req_unsigned(req_unsigned), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_error(rsp_error), .o_rsp_rdata(rsp_rdata),
    .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_write(mem_write),
    .o_mem_addr(mem_addr), .o_mem_strb(mem_strb), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .i_mem_error(mem_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Presents a request at a negedge; returns in the first cycle after acceptance (T+1)
  task automatic issue(input logic st, input logic [1:0] sz, input logic un,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = un;
    req_addr = addr; req_wdata = wd;
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic single(input string tag, input logic st, input logic [1:0] sz, input logic un,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                        input logic [3:0] e_strb, input logic [31:0] e_wd, input logic [31:0] e_rd);
    mem_ready = 1'b1; mem_error = 1'b0; mem_rdata = rd;
    issue(st, sz, un, addr, wd);
    chk({tag, "_mvalid"}, 64'(mem_valid), 64'd1);
    chk({tag, "_maddr"}, 64'(mem_addr), 64'(addr & 32'hFFFF_FFFC));
    chk({tag, "_strb"}, 64'(mem_strb), 64'(e_strb));
    chk({tag, "_write"}, 64'(mem_write), 64'(st));
    if (st) chk({tag, "_wdata"}, 64'(mem_wdata), 64'(e_wd));
    chk({tag, "_busy"}, 64'(req_ready), 64'd0);
    cyc();
    chk({tag, "_rvalid"}, 64'(rsp_valid), 64'd1);
    chk({tag, "_rerr"}, 64'(rsp_error), 64'd0);
    chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(e_rd));
    chk({tag, "_mdone"}, 64'(mem_valid), 64'd0);
    cyc();
    chk({tag, "_idle"}, 64'(req_ready), 64'd1);
    chk({tag, "_pulse"}, 64'(rsp_valid), 64'd0);
  endtask

  task automatic early_err(input string tag, input logic [1:0] sz, input logic [31:0] addr);
    mem_ready = 1'b1; mem_error = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    issue(1'b0, sz, 1'b0, addr, 32'h0);
    chk({tag, "_rvalid"}, 64'(rsp_valid), 64'd1);
    chk({tag, "_rerr"}, 64'(rsp_error), 64'd1);
    chk({tag, "_rdata"}, 64'(rsp_rdata), 64'd0);
    chk({tag, "_nobeat"}, 64'(mem_valid), 64'd0);
    cyc();
    chk({tag, "_idle"}, 64'(req_ready), 64'd1);
    chk({tag, "_errclr"}, 64'(rsp_error), 64'd0);
  endtask

  initial begin
    req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    mem_ready = 1'b0; mem_error = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_mvalid", 64'(mem_valid), 64'd0);
    chk("rst_rvalid", 64'(rsp_valid), 64'd0);
    chk("rst_rerr", 64'(rsp_error), 64'd0);
    chk("rst_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_strb", 64'(mem_strb), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    single("lb103", 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h8000_0000, 4'h8, 32'h0, 32'hFFFF_FF80);
    single("lbu103", 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h8000_0000, 4'h8, 32'h0, 32'h0000_0080);
    single("lh102", 1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'h8001_1234, 4'hC, 32'h0, 32'hFFFF_8001);
    single("lhu102", 1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'h8001_1234, 4'hC, 32'h0, 32'h0000_8001);
    single("lw200", 1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 32'hDEAD_BEEF, 4'hF, 32'h0, 32'hDEAD_BEEF);
    single("lb100", 1'b0, 2'd0, 1'b0, 32'h100, 32'h0, 32'h1234_567F, 4'h1, 32'h0, 32'h0000_007F);
    single("sb101", 1'b1, 2'd0, 1'b0, 32'h101, 32'h0000_00AA, 32'hFFFF_FFFF, 4'h2, 32'h0000_AA00, 32'h0);
    single("sw300", 1'b1, 2'd2, 1'b0, 32'h300, 32'hCAFE_F00D, 32'h0, 4'hF, 32'hCAFE_F00D, 32'h0);

    // Store with three stalled cycles: beat held, response at T+5
    mem_ready = 1'b0; mem_error = 1'b0;
    issue(1'b1, 2'd1, 1'b0, 32'h202, 32'h1234_ABCD);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("sh_stall%0d_valid", i), 64'(mem_valid), 64'd1);
      chk($sformatf("sh_stall%0d_strb", i), 64'(mem_strb), 64'hC);
      chk($sformatf("sh_stall%0d_wdata", i), 64'(mem_wdata), 64'hABCD_0000);
      chk($sformatf("sh_stall%0d_addr", i), 64'(mem_addr), 64'h200);
      chk($sformatf("sh_stall%0d_rsp", i), 64'(rsp_valid), 64'd0);
      if (i == 4) mem_ready = 1'b1;
      cyc();
    end
    chk("sh_rvalid", 64'(rsp_valid), 64'd1);
    chk("sh_rerr", 64'(rsp_error), 64'd0);
    chk("sh_rdata", 64'(rsp_rdata), 64'd0);
    cyc();

    // Bus error on a single beat
    mem_ready = 1'b1; mem_error = 1'b1; mem_rdata = 32'h1111_1111;
    issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    chk("berr_mvalid", 64'(mem_valid), 64'd1);
    cyc();
    chk("berr_rvalid", 64'(rsp_valid), 64'd1);
    chk("berr_rerr", 64'(rsp_error), 64'd1);
    chk("berr_rdata", 64'(rsp_rdata), 64'd0);
    mem_error = 1'b0;
    cyc();

    early_err("size3", 2'd3, 32'h100);

`ifdef MISALIGNED_EN
    single("lh101", 1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 32'h00AB_CD00, 4'h6, 32'h0, 32'hFFFF_ABCD);

    // Crossing word: two beats, response at T+3
    mem_ready = 1'b1; mem_error = 1'b0; mem_rdata = 32'hBEEF_0000;
    issue(1'b0, 2'd2, 1'b0, 32'h0FE, 32'h0);
    chk("split_b0_addr", 64'(mem_addr), 64'h0FC);
    chk("split_b0_strb", 64'(mem_strb), 64'hC);
    mem_rdata = 32'h0000_CAFE;
    cyc();
    chk("split_b1_valid", 64'(mem_valid), 64'd1);
    chk("split_b1_addr", 64'(mem_addr), 64'h100);
    chk("split_b1_strb", 64'(mem_strb), 64'h3);
    chk("split_b1_norsp", 64'(rsp_valid), 64'd0);
    cyc();
    chk("split_rvalid", 64'(rsp_valid), 64'd1);
    chk("split_rdata", 64'(rsp_rdata), 64'hCAFE_BEEF);
    chk("split_rerr", 64'(rsp_error), 64'd0);
    cyc();

    // Wrapping split store; bus error on beat0 ends the access after one beat
    mem_ready = 1'b0;
    issue(1'b1, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h1234_5678);
    chk("wrap_b0_addr", 64'(mem_addr), 64'hFFFF_FFFC);
    chk("wrap_b0_wdata", 64'(mem_wdata), 64'h5678_0000);
    mem_ready = 1'b1; mem_error = 1'b1;
    cyc();
    chk("wrap_err_rvalid", 64'(rsp_valid), 64'd1);
    chk("wrap_err_rerr", 64'(rsp_error), 64'd1);
    chk("wrap_err_nobeat1", 64'(mem_valid), 64'd0);
    mem_error = 1'b0;
    cyc();
    mem_ready = 1'b0;
    issue(1'b1, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h1234_5678);
    mem_ready = 1'b1;
    cyc();
    chk("wrap_b1_addr", 64'(mem_addr), 64'h0);
    chk("wrap_b1_strb", 64'(mem_strb), 64'h3);
    chk("wrap_b1_wdata", 64'(mem_wdata), 64'h0000_1234);
    cyc();
    chk("wrap_rvalid", 64'(rsp_valid), 64'd1);
    cyc();
`else
    early_err("lw0fe_misal", 2'd2, 32'h0FE);
    early_err("lh101_misal", 2'd1, 32'h101);
`endif

    // Asynchronous reset while a beat is stalled
    mem_ready = 1'b0; mem_error = 1'b0;
    issue(1'b0, 2'd2, 1'b0, 32'h300, 32'h0);
    chk("rst_mid_mvalid_before", 64'(mem_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_mvalid", 64'(mem_valid), 64'd0);
    chk("rst_mid_ready", 64'(req_ready), 64'd1);
    chk("rst_mid_rvalid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("rst_after%0d_rvalid", i), 64'(rsp_valid), 64'd0);
      chk($sformatf("rst_after%0d_mvalid", i), 64'(mem_valid), 64'd0);
    end

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
